climate_classifier_mc: RTL and testbench

Multi-channel, parametrised climate classifier for the climate prediction subsystem. It accepts temperature/pressure samples from NUM_CH sensor stations over a valid/ready stream and keeps a per-channel block average over 2^AVG_LOG2 samples. Each completed average is classified as SNOW, SUNNY, STORM or ERROR against parametrised inclusive windows, and the result is emitted on a valid/ready output stream.

---
 rtl/climate_classifier_mc.sv | 181 ++++++++++++++++++
 tb/tb_climate_classifier_mc.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/climate_classifier_mc.sv
// Multi-channel block-averaging climate classifier with valid/ready streams.
// Optional CLIMATE_CHANGE_ONLY_EN: emit a result only when a channel's class changes.
module climate_classifier_mc #(
    parameter int NUM_CH   = 4,
    parameter int AVG_LOG2 = 2,
    parameter int TW       = 32,
    parameter int PW       = 32,
    parameter logic signed [TW-1:0] SNOW_T_MIN  = TW'(-20),
    parameter logic signed [TW-1:0] SNOW_T_MAX  = TW'(10),
    parameter logic [PW-1:0]        SNOW_P_MIN  = PW'(900),
    parameter logic [PW-1:0]        SNOW_P_MAX  = PW'(1050),
    parameter logic signed [TW-1:0] SUN_T_MIN   = TW'(11),
    parameter logic signed [TW-1:0] SUN_T_MAX   = TW'(50),
    parameter logic [PW-1:0]        SUN_P_MIN   = PW'(1051),
    parameter logic [PW-1:0]        SUN_P_MAX   = PW'(1120),
    parameter logic signed [TW-1:0] STORM_T_MIN = TW'(51),
    parameter logic [PW-1:0]        STORM_P_MAX = PW'(899),
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CW-1:0]        in_chan,
    input  logic signed [TW-1:0] in_temp,
    input  logic [PW-1:0]        in_press,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        out_chan,
    output logic [1:0]           out_class,
    output logic signed [TW-1:0] out_avg_temp,
    output logic [PW-1:0]        out_avg_press,
    output logic                 bad_chan
);

    localparam int TAW = TW + AVG_LOG2;
    localparam int PAW = PW + AVG_LOG2;
    localparam int CNW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, CLASSIFY, OUTPUT} state_t;

    state_t state_q, state_d;

    logic [CW-1:0]         chan_q;
    logic signed [TW-1:0]  temp_q;
    logic [PW-1:0]         press_q;
    logic signed [TAW-1:0] acc_t_q [NUM_CH];
    logic [PAW-1:0]        acc_p_q [NUM_CH];
    logic [CNW-1:0]        cnt_q   [NUM_CH];

    logic [CW-1:0]         out_chan_q;
    logic [1:0]            out_class_q;
    logic signed [TW-1:0]  out_avg_temp_q;
    logic [PW-1:0]         out_avg_press_q;

    logic                  take;
    logic                  chan_ok;
    logic                  blk_done;
    logic                  emit;
    logic signed [TAW-1:0] sum_t;
    logic [PAW-1:0]        sum_p;
    logic signed [TW-1:0]  avg_t;
    logic [PW-1:0]         avg_p;
    logic [1:0]            cls;

`ifdef CLIMATE_CHANGE_ONLY_EN
    // bit 2 set means no class has been reported yet
    logic [2:0]            last_q [NUM_CH];
`endif

    assign take     = in_valid && (state_q == IDLE) && !rst;
    assign chan_ok  = {1'b0, chan_q} < (CW+1)'(NUM_CH);
    assign blk_done = chan_ok && ((AVG_LOG2 == 0) || (&cnt_q[chan_q]));
    assign sum_t    = acc_t_q[chan_q];
    assign sum_p    = acc_p_q[chan_q];
    assign avg_t    = TW'(sum_t >>> AVG_LOG2);
    assign avg_p    = PW'(sum_p >> AVG_LOG2);

`ifdef CLIMATE_CHANGE_ONLY_EN
    assign emit = ({1'b0, cls} != last_q[chan_q]);
`else
    assign emit = 1'b1;
`endif

    assign out_chan      = out_chan_q;
    assign out_class     = out_class_q;
    assign out_avg_temp  = out_avg_temp_q;
    assign out_avg_press = out_avg_press_q;

    // Classify the averaged sample; earlier windows take priority
    always_comb begin
        cls = 2'd3;
        if (avg_t >= SNOW_T_MIN && avg_t <= SNOW_T_MAX &&
            avg_p >= SNOW_P_MIN && avg_p <= SNOW_P_MAX) begin
            cls = 2'd0;
        end else if (avg_t >= SUN_T_MIN && avg_t <= SUN_T_MAX &&
                     avg_p >= SUN_P_MIN && avg_p <= SUN_P_MAX) begin
            cls = 2'd1;
        end else if (avg_t >= STORM_T_MIN && avg_p <= STORM_P_MAX) begin
            cls = 2'd2;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        bad_chan  = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) state_d = ACCUM;
            end
            ACCUM: begin
                bad_chan = !chan_ok && !rst;
                state_d  = blk_done ? CLASSIFY : IDLE;
            end
            CLASSIFY: begin
                state_d = emit ? OUTPUT : IDLE;
            end
            OUTPUT: begin
                out_valid = !rst;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sample capture, per-channel accumulation and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            chan_q          <= '0;
            temp_q          <= '0;
            press_q         <= '0;
            out_chan_q      <= '0;
            out_class_q     <= '0;
            out_avg_temp_q  <= '0;
            out_avg_press_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_t_q[i] <= '0;
                acc_p_q[i] <= '0;
                cnt_q[i]   <= '0;
`ifdef CLIMATE_CHANGE_ONLY_EN
                last_q[i]  <= 3'b100;
`endif
            end
        end else begin
            if (take) begin
                chan_q  <= in_chan;
                temp_q  <= in_temp;
                press_q <= in_press;
            end
            if (state_q == ACCUM && chan_ok) begin
                acc_t_q[chan_q] <= acc_t_q[chan_q] + TAW'(temp_q);
                acc_p_q[chan_q] <= acc_p_q[chan_q] + PAW'(press_q);
                cnt_q[chan_q]   <= blk_done ? '0 : CNW'(cnt_q[chan_q] + 1'b1);
            end
            if (state_q == CLASSIFY) begin
                acc_t_q[chan_q] <= '0;
                acc_p_q[chan_q] <= '0;
                if (emit) begin
                    out_chan_q      <= chan_q;
                    out_class_q     <= cls;
                    out_avg_temp_q  <= avg_t;
                    out_avg_press_q <= avg_p;
`ifdef CLIMATE_CHANGE_ONLY_EN
                    last_q[chan_q]  <= {1'b0, cls};
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_climate_classifier_mc.sv
// Self-checking bench for climate_classifier_mc (directed scenarios plus
// randomized traffic checked against a block-average reference model).
module tb_climate_classifier_mc;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [1:0]         in_chan = '0;
    logic signed [31:0] in_temp = '0;
    logic [31:0]        in_press = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [1:0]         out_chan;
    logic [1:0]         out_class;
    logic signed [31:0] out_avg_temp;
    logic [31:0]        out_avg_press;
    logic               bad_chan;

    typedef struct {
        int     ch;
        int     cls;
        longint t;
        longint p;
    } res_t;

    res_t got[$];
    res_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_acc = 0;

    climate_classifier_mc dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_chan(in_chan),
        .in_temp(in_temp),
        .in_press(in_press),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_chan(out_chan),
        .out_class(out_class),
        .out_avg_temp(out_avg_temp),
        .out_avg_press(out_avg_press),
        .bad_chan(bad_chan)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready)
            got.push_back('{int'(out_chan), int'(out_class),
                            longint'(out_avg_temp), longint'(out_avg_press)});
    end

    function automatic longint floor_div(longint s, longint n);
        if (s >= 0) return s / n;
        return -((-s + n - 1) / n);
    endfunction

    function automatic int classify(longint t, longint p);
        if (t >= -20 && t <= 10 && p >= 900 && p <= 1050) return 0;
        if (t >= 11 && t <= 50 && p >= 1051 && p <= 1120) return 1;
        if (t >= 51 && p <= 899) return 2;
        return 3;
    endfunction

    task automatic send(input int ch, input int t, input int p);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_chan  = 2'(ch);
        in_temp  = 32'(t);
        in_press = 32'(p);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        last_acc = cyc;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_res(input int n);
        int k;
        k = 0;
        while (got.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (got.size() < n) begin
            total++;
            bad++;
            $display("FAIL wait_results: got=%0d required=%0d", got.size(), n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({out_valid, in_ready, out_chan, out_class, out_avg_temp,
             out_avg_press, bad_chan} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: v=%b r=%b ch=%0d cls=%0d t=%0d p=%0d bad=%b required all 0",
                     out_valid, in_ready, out_chan, out_class, out_avg_temp, out_avg_press, bad_chan);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_idle_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_snow_latency();
        res_t r;
        for (int i = 0; i < 4; i++) send(0, 0, 1000);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL busy_ready k=%0d: in_ready=%b required 0", k, in_ready);
            end
            total++;
            if (out_valid !== (k == 3)) begin
                bad++;
                $display("FAIL latency k=%0d: out_valid=%b required %b", k, out_valid, k == 3);
            end
        end
        total++;
        if (cyc - last_acc != 3) begin
            bad++;
            $display("FAIL latency_cycles: got=%0d required 3", cyc - last_acc);
        end
        wait_res(1);
        if (got.size() > 0) begin
            r = got.pop_front();
            total++;
            if (r.ch !== 0 || r.cls !== 0 || r.t !== 0 || r.p !== 1000) begin
                bad++;
                $display("FAIL snow_basic: ch=%0d cls=%0d t=%0d p=%0d required 0 0 0 1000",
                         r.ch, r.cls, r.t, r.p);
            end
        end
    endtask

    task automatic test_interleave();
        res_t r;
        int t1[4] = '{-21, -19, -21, -19};
        int t2[4] = '{10, 12, 10, 12};
        for (int i = 0; i < 4; i++) begin
            send(1, t1[i], 900);
            send(2, t2[i], 1051);
        end
        wait_res(2);
        if (got.size() >= 2) begin
            r = got.pop_front();
            total++;
            if (r.ch !== 1 || r.cls !== 0 || r.t !== -20 || r.p !== 900) begin
                bad++;
                $display("FAIL interleave_ch1: ch=%0d cls=%0d t=%0d p=%0d required 1 0 -20 900",
                         r.ch, r.cls, r.t, r.p);
            end
            r = got.pop_front();
            total++;
            if (r.ch !== 2 || r.cls !== 1 || r.t !== 11 || r.p !== 1051) begin
                bad++;
                $display("FAIL interleave_ch2: ch=%0d cls=%0d t=%0d p=%0d required 2 1 11 1051",
                         r.ch, r.cls, r.t, r.p);
            end
        end
    endtask

    task automatic test_classes();
        res_t r;
        int tf[4] = '{-1, -1, -1, -2};
        for (int i = 0; i < 4; i++) send(3, 60, 850);
        for (int i = 0; i < 4; i++) send(0, 50, 899);
        for (int i = 0; i < 4; i++) send(1, tf[i], 1000);
        wait_res(3);
        if (got.size() >= 3) begin
            r = got.pop_front();
            total++;
            if (r.ch !== 3 || r.cls !== 2 || r.t !== 60 || r.p !== 850) begin
                bad++;
                $display("FAIL storm: ch=%0d cls=%0d t=%0d p=%0d required 3 2 60 850",
                         r.ch, r.cls, r.t, r.p);
            end
            r = got.pop_front();
            total++;
            if (r.ch !== 0 || r.cls !== 3 || r.t !== 50 || r.p !== 899) begin
                bad++;
                $display("FAIL error_class: ch=%0d cls=%0d t=%0d p=%0d required 0 3 50 899",
                         r.ch, r.cls, r.t, r.p);
            end
            r = got.pop_front();
            total++;
            if (r.ch !== 1 || r.cls !== 0 || r.t !== -2 || r.p !== 1000) begin
                bad++;
                $display("FAIL floor_avg: ch=%0d cls=%0d t=%0d p=%0d required 1 0 -2 1000",
                         r.ch, r.cls, r.t, r.p);
            end
        end
    endtask

    task automatic test_backpressure();
        int k;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2, 20, 1100);
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        in_valid = 1'b1;
        in_chan  = 2'd3;
        in_temp  = 32'sd70;
        in_press = 32'd800;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1) begin
                bad++;
                $display("FAIL bp_valid i=%0d: out_valid=%b required 1", i, out_valid);
            end
            total++;
            if (out_chan !== 2'd2 || out_class !== 2'd1 ||
                out_avg_temp !== 32'sd20 || out_avg_press !== 32'd1100) begin
                bad++;
                $display("FAIL bp_hold i=%0d: ch=%0d cls=%0d t=%0d p=%0d required 2 1 20 1100",
                         i, out_chan, out_class, out_avg_temp, out_avg_press);
            end
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_in_ready i=%0d: in_ready=%b required 0", i, in_ready);
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        total++;
        if (got.size() != 1) begin
            bad++;
            $display("FAIL bp_count: results=%0d required 1", got.size());
        end
    endtask

    task automatic test_reset_mid();
        res_t r;
        do_reset();
        send(0, 100, 500);
        send(0, 100, 500);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({out_valid, in_ready, out_chan, out_class, out_avg_temp,
             out_avg_press, bad_chan} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: v=%b r=%b ch=%0d cls=%0d t=%0d p=%0d bad=%b required all 0",
                     out_valid, in_ready, out_chan, out_class, out_avg_temp, out_avg_press, bad_chan);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) send(0, 0, 1000);
        wait_res(1);
        repeat (10) @(negedge clk);
        total++;
        if (got.size() != 1) begin
            bad++;
            $display("FAIL midreset_count: results=%0d required 1", got.size());
        end
        if (got.size() > 0) begin
            r = got.pop_front();
            total++;
            if (r.ch !== 0 || r.cls !== 0 || r.t !== 0 || r.p !== 1000) begin
                bad++;
                $display("FAIL midreset_result: ch=%0d cls=%0d t=%0d p=%0d required 0 0 0 1000",
                         r.ch, r.cls, r.t, r.p);
            end
        end
    endtask

`ifdef CLIMATE_CHANGE_ONLY_EN
    task automatic test_change_only();
        do_reset();
        for (int i = 0; i < 12; i++) send(0, 0, 1000);
        for (int i = 0; i < 4; i++) send(0, 60, 850);
        wait_res(2);
        repeat (10) @(negedge clk);
        total++;
        if (got.size() != 2) begin
            bad++;
            $display("FAIL change_count: results=%0d required 2", got.size());
        end
        if (got.size() >= 2) begin
            total++;
            if (got[0].cls !== 0 || got[1].cls !== 2) begin
                bad++;
                $display("FAIL change_classes: got %0d,%0d required 0,2", got[0].cls, got[1].cls);
            end
        end
    endtask
`endif

    task automatic test_random();
        longint st[4];
        longint sp[4];
        int     cnt[4];
        int     last[4];
        bit     done;
        int     k;
        res_t   r;
        res_t   e;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            st[c] = 0;
            sp[c] = 0;
            cnt[c] = 0;
            last[c] = -1;
        end
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 200; n++) begin
                    int ch;
                    int f;
                    int t;
                    int p;
                    ch = int'($urandom_range(0, 3));
                    f  = int'($urandom_range(0, 3));
                    case (f)
                        0: begin t = int'($urandom_range(0, 30)) - 20; p = int'($urandom_range(900, 1050)); end
                        1: begin t = int'($urandom_range(11, 50)); p = int'($urandom_range(1051, 1120)); end
                        2: begin t = int'($urandom_range(51, 90)); p = int'($urandom_range(850, 899)); end
                        default: begin t = int'($urandom_range(0, 300)) - 100; p = int'($urandom_range(0, 2000)); end
                    endcase
                    send(ch, t, p);
                    st[ch] += t;
                    sp[ch] += p;
                    cnt[ch]++;
                    if (cnt[ch] == 4) begin
                        e.ch  = ch;
                        e.t   = floor_div(st[ch], 4);
                        e.p   = sp[ch] / 4;
                        e.cls = classify(e.t, e.p);
`ifdef CLIMATE_CHANGE_ONLY_EN
                        if (e.cls != last[ch]) begin
                            exp_q.push_back(e);
                            last[ch] = e.cls;
                        end
`else
                        exp_q.push_back(e);
`endif
                        st[ch] = 0;
                        sp[ch] = 0;
                        cnt[ch] = 0;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_res(exp_q.size());
        repeat (10) @(negedge clk);
        total++;
        if (got.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rand_count: results=%0d required %0d", got.size(), exp_q.size());
        end
        k = 0;
        while (got.size() > 0 && exp_q.size() > 0) begin
            r = got.pop_front();
            e = exp_q.pop_front();
            total++;
            if (r.ch !== e.ch || r.cls !== e.cls || r.t !== e.t || r.p !== e.p) begin
                bad++;
                $display("FAIL rand_result #%0d: ch=%0d cls=%0d t=%0d p=%0d required %0d %0d %0d %0d",
                         k, r.ch, r.cls, r.t, r.p, e.ch, e.cls, e.t, e.p);
            end
            k++;
        end
    endtask

    initial begin
        test_reset();
        test_snow_latency();
        test_interleave();
        test_classes();
        test_backpressure();
        test_reset_mid();
`ifdef CLIMATE_CHANGE_ONLY_EN
        test_change_only();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
